// File: rtl/pipe_pkg.sv
// Shared MEM-stage definitions: FSM state encoding and default widths.
`timescale 1ns/1ps
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WORD_W     = 32;
    localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Counts BUSY cycles of one memory access; expired flags the last allowed cycle.
`timescale 1ns/1ps
module dmem_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;

    // Asserted during the TIMEOUT_CYCLES-th BUSY cycle, so the FSM leaves at its end.
    assign expired = en && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, pipeline stall and load-data latch.
// Optional BUSY timeout with sticky mem_err is enabled by defining DMEM_TIMEOUT_EN.
`timescale 1ns/1ps
module dmem_access_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread_m,
    input  logic              memwrite_m,
    input  logic [WORD_W-1:0] execout_m,
    input  logic [WORD_W-1:0] writedata_m,
    output logic              stall,
    output logic [WORD_W-1:0] readdata_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              misalign_err,
    output logic              mem_err
);

    state_t state_reg;
    logic   access;
    logic   aligned;
    logic   unused_bits;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign access      = memread_m | memwrite_m;
    assign aligned     = (execout_m[1:0] == 2'b00);
    assign unused_bits = ^execout_m[WORD_W-1:ADDR_W+2];

    // DONE never stalls: the pipeline advances exactly once per completed access.
    assign stall = ((state_reg == IDLE) && access) || (state_reg == BUSY);

`ifdef DMEM_TIMEOUT_EN
    logic expired;

    dmem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    ((state_reg == IDLE) && access && aligned),
        .en     (state_reg == BUSY),
        .expired(expired)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            readdata_m   <= '0;
            misalign_err <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            // Write wins when both load and store flags are set.
                            mem_req   <= 1'b1;
                            mem_we    <= memwrite_m;
                            mem_addr  <= execout_m[ADDR_W+1:2];
                            mem_wdata <= writedata_m;
                            state_reg <= BUSY;
                        end else begin
                            misalign_err <= 1'b1;
                            readdata_m   <= '0;
                            state_reg    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            readdata_m <= mem_rdata;
                        end
                        state_reg <= DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (expired) begin
                        mem_req    <= 1'b0;
                        readdata_m <= '0;
                        mem_err    <= 1'b1;
                        state_reg  <= DONE;
                    end
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver queues expected issues/completions, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread_m = 1'b0;
    logic        memwrite_m = 1'b0;
    logic [31:0] execout_m = '0;
    logic [31:0] writedata_m = '0;
    logic        stall;
    logic [31:0] readdata_m;
    logic        mem_req;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        misalign_err;
    logic        mem_err;

    dmem_access_ctrl #(
        .ADDR_W        (AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memread_m   (memread_m),
        .memwrite_m  (memwrite_m),
        .execout_m   (execout_m),
        .writedata_m (writedata_m),
        .stall       (stall),
        .readdata_m  (readdata_m),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .misalign_err(misalign_err),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        bit            b2b;
    } issue_t;

    typedef struct {
        int          stall_cycles;
        logic [31:0] rdata;
        logic        misalign;
        logic        err;
    } done_t;

    issue_t issue_q[$];
    done_t  done_q[$];
    issue_t it;
    done_t  dt;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cyc = -100;
    int   stall_run = 0;
    logic prev_stall = 1'b0;
    logic prev_req = 1'b0;
    logic prev_reset = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endfunction

    // Monitor: mem_req rising edge = issue, stall falling edge = DONE cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset && prev_reset) begin
            if (mem_req && !prev_req) begin
                if (issue_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL issue: unexpected mem_req addr=0x%04h, expected none", mem_addr);
                end else begin
                    it = issue_q.pop_front();
                    check("issue_we", 32'(mem_we), 32'(it.we));
                    check("issue_addr", 32'(mem_addr), 32'(it.addr));
                    check("issue_wdata", mem_wdata, it.wdata);
                    if (it.b2b) check("b2b_gap", 32'(cyc - done_cyc), 32'd2);
                end
            end
            if (misalign_err && (stall || !prev_stall)) begin
                n_checks++;
                n_fail++;
                $display("FAIL misalign_pulse: got 1 outside DONE, expected 0");
            end
            if (stall) begin
                stall_run++;
            end else if (prev_stall) begin
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done: unexpected completion after %0d stall cycles, expected none", stall_run);
                end else begin
                    dt = done_q.pop_front();
                    check("done_stall_cycles", 32'(stall_run), 32'(dt.stall_cycles));
                    check("done_readdata", readdata_m, dt.rdata);
                    check("done_misalign", 32'(misalign_err), 32'(dt.misalign));
                    check("done_mem_err", 32'(mem_err), 32'(dt.err));
                    check("done_mem_req", 32'(mem_req), 32'd0);
                end
                stall_run = 0;
            end
        end else begin
            stall_run = 0;
        end
        prev_stall = stall;
        prev_req   = mem_req;
        prev_reset = reset;
    end

    // Drives one access starting in an IDLE cycle; acks in BUSY cycle ack_at (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
        bit done = 0;
        int busy = 0;
        memread_m   = rd;
        memwrite_m  = wr;
        execout_m   = addr;
        writedata_m = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                busy++;
                if (busy == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_bound: access at 0x%08h still busy after 200 cycles", addr);
        end
        @(posedge clk);
        #1;
        memread_m  = 1'b0;
        memwrite_m = 1'b0;
        mem_ack    = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_readdata", readdata_m, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Aligned load, ack in the third BUSY cycle.
        issue_q.push_back('{we: 1'b0, addr: 16'h0004, wdata: 32'h0, b2b: 0});
        done_q.push_back('{stall_cycles: 4, rdata: 32'hCAFE_F00D, misalign: 1'b0, err: 1'b0});
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hCAFE_F00D);
        repeat (2) @(posedge clk);
        #1;

        // Store, ack in the first BUSY cycle; readdata_m keeps the load value.
        issue_q.push_back('{we: 1'b1, addr: 16'h0008, wdata: 32'h1234_5678, b2b: 0});
        done_q.push_back('{stall_cycles: 2, rdata: 32'hCAFE_F00D, misalign: 1'b0, err: 1'b0});
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'h5555_AAAA);
        repeat (2) @(posedge clk);
        #1;

        // Misaligned load: no request, one stall cycle, readdata_m cleared.
        done_q.push_back('{stall_cycles: 1, rdata: 32'h0, misalign: 1'b1, err: 1'b0});
        do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h7777_7777);
        repeat (2) @(posedge clk);
        #1;

        // Load then back-to-back access with both flags set (write wins).
        issue_q.push_back('{we: 1'b0, addr: 16'h0010, wdata: 32'h9999_0000, b2b: 0});
        done_q.push_back('{stall_cycles: 3, rdata: 32'h1111_2222, misalign: 1'b0, err: 1'b0});
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h9999_0000, 2, 32'h1111_2222);
        issue_q.push_back('{we: 1'b1, addr: 16'h0011, wdata: 32'hA5A5_0F0F, b2b: 1});
        done_q.push_back('{stall_cycles: 2, rdata: 32'h1111_2222, misalign: 1'b0, err: 1'b0});
        do_access(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_0F0F, 1, 32'h3333_4444);
        repeat (2) @(posedge clk);
        #1;

        // Reset during BUSY, then a late ack that must be ignored.
        issue_q.push_back('{we: 1'b0, addr: 16'h0040, wdata: 32'h0, b2b: 0});
        memread_m = 1'b1;
        execout_m = 32'h0000_0100;
        writedata_m = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        memread_m = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_readdata", readdata_m, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("late_ack_readdata", readdata_m, 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // No ack: four BUSY cycles, then DONE with sticky mem_err.
        issue_q.push_back('{we: 1'b0, addr: 16'h0020, wdata: 32'h0, b2b: 0});
        done_q.push_back('{stall_cycles: 5, rdata: 32'h0, misalign: 1'b0, err: 1'b1});
        do_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("timeout_err_sticky", 32'(mem_err), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("timeout_err_cleared", 32'(mem_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`endif

        check("issue_q_empty", 32'(issue_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
